// File: rtl/tug_pkg.sv
// Shared types and defaults for the tug-of-war player input front end.
package tug_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } btn_state_t;

   localparam int DEBOUNCE_DEFAULT = 1_000_000;

endpackage

// File: rtl/button_conditioner.sv
// One push-button channel: polarity fix, 2-FF synchroniser, debounce FSM and a
// registered single-cycle pulse emitted only on a completed debounced press.
module button_conditioner
   import tug_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic key,
   output logic pulse
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          key_pressed;
   logic          sync1_q;
   logic          sync2_q;
   btn_state_t    state_q;
   logic [CW-1:0] cnt_q;
   logic          pulse_q;
   logic          at_last;

   assign key_pressed = KEY_ACTIVE_LOW ? ~key : key;
   assign at_last     = (cnt_q == CNT_LAST);
   assign pulse       = pulse_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= key_pressed;
         sync2_q <= sync1_q;
         pulse_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (sync2_q) begin
                  state_q <= PRESS_WAIT;
                  cnt_q   <= CNT_ONE;
               end
            end
            PRESS_WAIT: begin
               if (!sync2_q) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (at_last) begin
                  // The only place a pulse can originate; a press finished while
                  // disabled is swallowed for good.
                  state_q <= HELD;
                  pulse_q <= enable;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            HELD: begin
               if (!sync2_q) begin
                  state_q <= RELEASE_WAIT;
                  cnt_q   <= CNT_ONE;
               end
            end
            RELEASE_WAIT: begin
               if (sync2_q) begin
                  state_q <= HELD;
                  cnt_q   <= '0;
               end else if (at_last) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/tug_player_inputs.sv
// Player input front end: one independent conditioner per player producing the
// L and R move pulses for the light chain.
module tug_player_inputs
   import tug_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic key_l,
   input  logic key_r,
   output logic L,
   output logic R
);

   button_conditioner #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
   ) u_left (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .key    (key_l),
      .pulse  (L)
   );

   button_conditioner #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
   ) u_right (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .key    (key_r),
      .pulse  (R)
   );

endmodule

// File: tb/tb_tug_player_inputs.sv
// Directed bench for tug_player_inputs: hand-written reset sequences followed by
// a per-cycle vector table (inputs plus expected L/R for that cycle).
module tb_tug_player_inputs;

   localparam int DC = 4;

   logic clk    = 1'b0;
   logic reset  = 1'b0;
   logic enable = 1'b1;
   logic key_l  = 1'b1;
   logic key_r  = 1'b1;
   logic L;
   logic R;

   int checks = 0;
   int errors = 0;

   always #10 clk = ~clk;

   tug_player_inputs #(
      .DEBOUNCE_CYCLES (DC),
      .KEY_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .key_l  (key_l),
      .key_r  (key_r),
      .L      (L),
      .R      (R)
   );

   typedef struct {
      logic  kl;
      logic  kr;
      logic  en;
      logic  el;
      logic  er;
      string tag;
   } vec_t;

   vec_t vq[$];

   // Append n cycles of constant inputs; pulse_l/pulse_r give the row index
   // (within this group) at which a pulse is expected, -1 for none.
   function automatic void add(int n, logic kl, logic kr, logic en,
                               int pulse_l, int pulse_r, string tag);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v.kl  = kl;
         v.kr  = kr;
         v.en  = en;
         v.el  = (i == pulse_l);
         v.er  = (i == pulse_r);
         v.tag = tag;
         vq.push_back(v);
      end
   endfunction

   task automatic check(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      // Reset held with left key pressed: outputs stay low.
      reset  = 1'b0;
      key_l  = 1'b0;
      key_r  = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rst_hold_L", L, 1'b0);
         check("rst_hold_R", R, 1'b0);
      end
      reset = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         cycle();
         check("rst_rel_L", L, (i == DC + 2));
         check("rst_rel_R", R, 1'b0);
      end
      $display("txn reset_release_with_key_held L_pulse_edge=%0d", DC + 2);

      key_l = 1'b1;
      repeat (8) cycle();

      // Fresh press; reset asserted asynchronously while the pulse is high.
      key_l = 1'b0;
      for (int i = 1; i <= DC + 2; i++) begin
         cycle();
         check("midrst_press_L", L, (i == DC + 2));
      end
      #5 reset = 1'b0;
      #1 check("midrst_async_L", L, 1'b0);
      @(negedge clk);
      check("midrst_hold_L", L, 1'b0);
      reset = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         cycle();
         check("midrst_rel_L", L, (i == DC + 2));
         check("midrst_rel_R", R, 1'b0);
      end
      $display("txn reset_mid_pulse async_clear_then_fresh_press");
      key_l = 1'b1;
      repeat (8) cycle();

      // Vector table.
      add(20, 1'b0, 1'b1, 1'b1, 5, -1, "clean_press_l");
      add(8,  1'b1, 1'b1, 1'b1, -1, -1, "idle");
      add(2,  1'b1, 1'b0, 1'b1, -1, -1, "bounce_r_lo");
      add(1,  1'b1, 1'b1, 1'b1, -1, -1, "bounce_r_hi");
      add(2,  1'b1, 1'b0, 1'b1, -1, -1, "bounce_r_lo");
      add(8,  1'b1, 1'b1, 1'b1, -1, -1, "idle");
      add(10, 1'b1, 1'b0, 1'b1, -1, 5, "stable_press_r");
      add(8,  1'b1, 1'b1, 1'b1, -1, -1, "idle");
      add(10, 1'b0, 1'b1, 1'b1, 5, -1, "held_l");
      add(2,  1'b1, 1'b1, 1'b1, -1, -1, "rel_bounce_hi");
      add(6,  1'b0, 1'b1, 1'b1, -1, -1, "rel_bounce_lo");
      add(8,  1'b1, 1'b1, 1'b1, -1, -1, "idle");
      add(DC - 1, 1'b0, 1'b1, 1'b1, -1, -1, "glitch_short_l");
      add(8,  1'b1, 1'b1, 1'b1, -1, -1, "idle");
      add(DC, 1'b0, 1'b1, 1'b1, -1, -1, "press_exact_l");
      add(8,  1'b1, 1'b1, 1'b1, 1, -1, "idle_after_exact");
      add(10, 1'b0, 1'b0, 1'b1, 5, 5, "simultaneous");
      add(8,  1'b1, 1'b1, 1'b1, -1, -1, "idle");
      add(8,  1'b0, 1'b1, 1'b0, -1, -1, "press_disabled_l");
      add(6,  1'b0, 1'b1, 1'b1, -1, -1, "enable_while_held");
      add(8,  1'b1, 1'b1, 1'b1, -1, -1, "idle");
      add(10, 1'b0, 1'b1, 1'b1, 5, -1, "repress_enabled_l");
      add(8,  1'b1, 1'b1, 1'b1, -1, -1, "idle");

      foreach (vq[i]) begin
         key_l  = vq[i].kl;
         key_r  = vq[i].kr;
         enable = vq[i].en;
         cycle();
         check({vq[i].tag, "_L"}, L, vq[i].el);
         check({vq[i].tag, "_R"}, R, vq[i].er);
         $display("txn %0d %s kl=%b kr=%b en=%b L=%b R=%b", i, vq[i].tag,
                  vq[i].kl, vq[i].kr, vq[i].en, L, R);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
